data_memory_controller: RTL

Parametrised data memory for the single-cycle computer. It replaces the read-only data RAM with a load/store memory that supports byte-enabled writes and a registered processor read port. It adds a debug display read port for the board switches/7-segment path and a sequential clear engine that zeroes every word after reset or on request. It sits between the processor's memory address/value signals and the top-level display mux.

---
 rtl/data_memory_controller.sv | 113 +++++++++++
 1 files changed

// File: rtl/data_memory_controller.sv
// Load/store data memory with byte-enabled writes, a registered processor
// read port, a debug display read port and a sequential clear engine that
// zeroes every word after reset or on request.
module data_memory_controller #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 6,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    output logic                      ready,
    input  logic [31:0]               address,
    input  logic [DATA_WIDTH-1:0]     write_value,
    input  logic                      write_enable,
    input  logic [DATA_WIDTH/8-1:0]   byte_enable,
    output logic [DATA_WIDTH-1:0]     read_value,
    output logic                      access_error,
    input  logic [ADDR_WIDTH-1:0]     display_address,
    output logic [DATA_WIDTH-1:0]     display_value
);

    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweep_count;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   word_index;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    bad_access;
    logic                    sweep_last;

    assign word_index   = address[ADDR_WIDTH+1:2];
    assign misaligned   = |address[1:0];
    assign out_of_range = |address[31:ADDR_WIDTH+2];
    assign bad_access   = misaligned | out_of_range;
    assign sweep_last   = (sweep_count == ADDR_WIDTH'(DEPTH - 1));

    // Sequencing FSM: sweep the array, then serve processor reads with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_CLEAR;
            sweep_count  <= '0;
            ready        <= 1'b0;
            read_value   <= '0;
            access_error <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    read_value   <= '0;
                    access_error <= 1'b0;
                    if (clear) begin
                        sweep_count <= '0;
                    end else if (sweep_last) begin
                        sweep_count <= '0;
                        state       <= ST_READY;
                        ready       <= 1'b1;
                    end else begin
                        sweep_count <= sweep_count + 1'b1;
                    end
                end
                ST_READY: begin
                    access_error <= bad_access;
                    // Array read happens before this edge's write lands, so a same-word store returns old data
                    read_value   <= bad_access ? '0 : mem[word_index];
                    if (clear) begin
                        state       <= ST_CLEAR;
                        sweep_count <= '0;
                        ready       <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_CLEAR;
                    sweep_count <= '0;
                    ready       <= 1'b0;
                end
            endcase
        end
    end

    // Debug display port reads in every state, one cycle latency
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            display_value <= '0;
        end else begin
            display_value <= mem[display_address];
        end
    end

    // Array writes: the sweep owns the array in CLEAR, byte-lane stores in READY
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[sweep_count] <= CLEAR_VALUE;
            end else if (write_enable && !bad_access) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (byte_enable[i]) begin
                        mem[word_index][8*i +: 8] <= write_value[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule
